uart_pkt_framer: RTL and testbench

//  Frames the 32-bit game-status word (board ID + BCD points) into a byte packet for the UART TX FIFO.

---
 rtl/uart_pkt_pkg.sv | 29 ++
 rtl/uart_pkt_framer_gap_timer.sv | 42 ++++
 rtl/uart_pkt_framer.sv | 150 +++++++++++++++
 tb/tb_uart_pkt_framer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared constants for the UART packet framer: header marker, state codes,
// packet geometry and the checksum helper.
// Optional feature macro: PKT_CHECKSUM_EN (adds a trailing XOR checksum byte).
package uart_pkt_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         DATA_BYTES     = 4;
  localparam int         PKT_LEN_PLAIN  = 1 + DATA_BYTES;
  localparam int         PKT_LEN_CSUM   = 2 + DATA_BYTES;

`ifdef PKT_CHECKSUM_EN
  localparam int         PKT_LEN        = PKT_LEN_CSUM;
`else
  localparam int         PKT_LEN        = PKT_LEN_PLAIN;
`endif

  // State encoding; CSUM is only reachable when the checksum is built in.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  // XOR of the four data bytes (header is not covered).
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/uart_pkt_framer_gap_timer.sv
// Inter-packet gap timer: loaded when the last byte is written, counts down
// while the framer sits in GAP and flags expiry on the final gap cycle so
// that exactly GAP_CYCLES write-free cycles separate packets (GAP + IDLE).
module pkt_gap_timer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int W = $clog2(GAP_CYCLES) + 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement while running and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(GAP_CYCLES - 1);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is seen while the count is about to hit zero, so the framer is
  // back in IDLE on the cycle the count reaches zero.
  assign expire = run && (cnt_q <= W'(1));

endmodule

// File: rtl/uart_pkt_framer.sv
// UART packet framer: turns a 32-bit status word into a header-delimited
// byte packet (HEADER, bytes MSB first[, XOR checksum]) for the UART TX FIFO.
// Optional feature macro: PKT_CHECKSUM_EN (6-byte packets with checksum).
//
// Handshake: a byte is transferred on every cycle where wr_uart=1. wr_uart is
// high in HDR/DATA/CSUM exactly when tx_full=0; while tx_full=1 the state and
// w_data hold, so bytes are never dropped or duplicated.
module uart_pkt_framer
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] HEADER     = HEADER_DEFAULT,
  parameter int         GAP_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        send_req,
  input  logic [31:0] data_in,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  logic [2:0]  state_q,   state_d;
  logic [1:0]  idx_q,     idx_d;
  logic        pending_q, pending_d;
  logic [31:0] shadow_q,  shadow_d;
  logic        done_q,    done_d;
  logic        gap_load;
  logic        gap_expire;
  logic        in_tx;

  assign in_tx   = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign wr_uart = in_tx && !tx_full;

  // Next-state logic: accept, walk the bytes on each write, then hold the gap.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    done_d    = 1'b0;
    gap_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (send_req || pending_q) begin
          shadow_d  = data_in;
          pending_d = 1'b0;
          idx_d     = 2'd0;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (wr_uart) begin
          idx_d   = 2'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wr_uart) begin
          if (idx_q == 2'd3) begin
            idx_d    = 2'd0;
`ifdef PKT_CHECKSUM_EN
            state_d  = ST_CSUM;
`else
            state_d  = ST_GAP;
            done_d   = 1'b1;
            gap_load = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
`ifdef PKT_CHECKSUM_EN
      ST_CSUM: begin
        if (wr_uart) begin
          state_d  = ST_GAP;
          done_d   = 1'b1;
          gap_load = 1'b1;
        end
      end
`endif
      ST_GAP: begin
        if (gap_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Requests arriving while a packet is in flight collapse into one.
    if (send_req && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end
  end

  // Framer state registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      pending_q <= 1'b0;
      shadow_q  <= 32'h0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      done_q    <= done_d;
    end
  end

  // Byte mux: pick the byte for the current state/index, zero when not sending.
  always_comb begin
    w_data = 8'h00;
    case (state_q)
      ST_HDR:  w_data = HEADER;
      ST_DATA: begin
        case (idx_q)
          2'd0:    w_data = shadow_q[31:24];
          2'd1:    w_data = shadow_q[23:16];
          2'd2:    w_data = shadow_q[15:8];
          default: w_data = shadow_q[7:0];
        endcase
      end
`ifdef PKT_CHECKSUM_EN
      ST_CSUM: w_data = xor_bytes(shadow_q);
`endif
      default: w_data = 8'h00;
    endcase
  end

  pkt_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (pclk),
    .rst_n  (rst),
    .load   (gap_load),
    .run    (state_q == ST_GAP),
    .expire (gap_expire)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_pkt_framer.sv
// Testbench for uart_pkt_framer. Honours PKT_CHECKSUM_EN for the expected
// packet length/contents.
module tb_uart_pkt_framer;

  localparam int GAP = 16;
`ifdef PKT_CHECKSUM_EN
  localparam int L = 6;
`else
  localparam int L = 5;
`endif

  logic        pclk;
  logic        rst_n;
  logic        send_req;
  logic [31:0] data_in;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  int         done_cnt;
  int         done_cyc;
  int         wr_while_full;

  uart_pkt_framer #(.HEADER(8'hA5), .GAP_CYCLES(GAP)) dut (
    .pclk      (pclk),
    .rst       (rst_n),
    .send_req  (send_req),
    .data_in   (data_in),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: record written bytes, done pulses and illegal writes on the falling edge
  always @(negedge pclk) begin
    if (rst_n) begin
      if (wr_uart) begin
        obs_q.push_back(w_data);
        obs_cyc.push_back(cyc);
        if (tx_full) wr_while_full++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference model: packet built from the word with plain byte arithmetic
  function automatic void push_pkt(input logic [31:0] w);
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) begin
      exp_q.push_back(w[i*8 +: 8]);
      cs = cs ^ w[i*8 +: 8];
    end
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  task automatic clear_obs();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    wr_while_full = 0;
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    @(posedge pclk); #1;
    send_req = 1'b0;
  endtask

  // Wait until busy has stayed low for 3 cycles (no pending packet), bounded.
  task automatic wait_quiet(input bit rand_stall, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(posedge pclk); #1;
      if (rand_stall) tx_full = ($urandom_range(0, 3) == 0);
      if (!busy) quiet++; else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    tx_full = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; send_req = 1'b0; data_in = 32'h0; tx_full = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checks++; if (wr_uart !== 1'b0) begin failures++; $display("FAIL reset_wr_uart got=%b exp=0", wr_uart); end
    checks++; if (w_data !== 8'h00) begin failures++; $display("FAIL reset_w_data got=%h exp=00", w_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int req_cyc;
    bit ok;
    clear_obs();
    data_in = 32'h0100_1234;
    push_pkt(data_in);
    req_cyc = cyc;
    pulse_req();
    wait_quiet(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout busy stuck"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL basic_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      checks++; if (obs_cyc[i] !== req_cyc + 1 + i) begin failures++; $display("FAIL basic_cycle%0d got=%0d exp=%0d", i, obs_cyc[i], req_cyc + 1 + i); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc !== req_cyc + L + 1) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, req_cyc + L + 1); end
  endtask

  task automatic test_stall();
    int n_before;
    bit ok;
    clear_obs();
    data_in = 32'h0100_1234;
    push_pkt(data_in);
    pulse_req();
    for (int n = 0; n < 50 && obs_q.size() < 2; n++) begin
      @(posedge pclk); #1;
    end
    tx_full  = 1'b1;
    n_before = obs_q.size();
    repeat (3) @(posedge pclk);
    #1;
    checks++; if (obs_q.size() !== n_before) begin failures++; $display("FAIL stall_no_write got=%0d exp=%0d", obs_q.size(), n_before); end
    checks++; if (wr_uart !== 1'b0) begin failures++; $display("FAIL stall_wr_uart got=%b exp=0", wr_uart); end
    tx_full = 1'b0;
    wait_quiet(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout busy stuck"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_pending();
    bit ok;
    clear_obs();
    data_in = $urandom;
    push_pkt(data_in);
    pulse_req();
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 3)) @(posedge pclk);
      #1;
      pulse_req();
      if (k == 0) data_in = 32'h0200_0099;
    end
    push_pkt(32'h0200_0099);
    wait_quiet(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pending_timeout busy stuck"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL pending_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL pending_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== 2) begin failures++; $display("FAIL pending_done_count got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_shadow();
    bit ok;
    clear_obs();
    data_in = 32'h1234_5678;
    push_pkt(data_in);
    pulse_req();
    for (int n = 0; n < 50 && obs_q.size() < 2; n++) begin
      @(posedge pclk); #1;
    end
    data_in = 32'hFFFF_FFFF;
    wait_quiet(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL shadow_timeout busy stuck"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL shadow_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL shadow_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    clear_obs();
    data_in = $urandom;
    pulse_req();
    for (int n = 0; n < 50 && obs_q.size() < 3; n++) begin
      @(posedge pclk); #1;
    end
    checks++; if (wr_uart !== 1'b1) begin failures++; $display("FAIL midrst_pre_wr got=%b exp=1", wr_uart); end
    rst_n = 1'b0;
    #1;
    checks++; if (wr_uart !== 1'b0) begin failures++; $display("FAIL midrst_wr_uart got=%b exp=0", wr_uart); end
    checks++; if (w_data !== 8'h00) begin failures++; $display("FAIL midrst_w_data got=%h exp=00", w_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk); #1;
    clear_obs();
    data_in = $urandom;
    push_pkt(data_in);
    pulse_req();
    wait_quiet(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout busy stuck"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL midrst_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  // send_req held: packets back to back; the request still high during the
  // third packet queues exactly one more, giving four packets in total.
  task automatic test_back_to_back();
    bit ok;
    int gap;
    clear_obs();
    data_in = $urandom;
    for (int p = 0; p < 4; p++) push_pkt(data_in);
    send_req = 1'b1;
    for (int n = 0; n < 200 && obs_q.size() < 2 * L + 1; n++) begin
      @(posedge pclk); #1;
    end
    send_req = 1'b0;
    wait_quiet(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout busy stuck"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    for (int p = 1; p < 4 && p * L < obs_q.size(); p++) begin
      gap = obs_cyc[p*L] - obs_cyc[p*L-1] - 1;
      checks++; if (gap !== GAP) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", p, gap, GAP); end
    end
    checks++; if (done_cnt !== 4) begin failures++; $display("FAIL b2b_done_count got=%0d exp=4", done_cnt); end
  endtask

  task automatic test_random();
    bit ok;
    for (int t = 0; t < 6; t++) begin
      clear_obs();
      data_in = $urandom;
      if (t == 0) data_in = 32'hA5A5_A5A5;
      push_pkt(data_in);
      pulse_req();
      wait_quiet(1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rand%0d_timeout busy stuck", t); end
      checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand%0d_len got=%0d exp=%0d", t, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]); end
      end
      checks++; if (wr_while_full !== 0) begin failures++; $display("FAIL rand%0d_wr_while_full got=%0d exp=0", t, wr_while_full); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rand%0d_done_count got=%0d exp=1", t, done_cnt); end
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_basic();
    test_stall();
    test_pending();
    test_shadow();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
